// File: rtl/input_keypad_scanner.sv
// 4x4 key matrix scanner: one-hot row drive, 2-flop column synchronizer,
// per-row settle timer and whole-scan debounce before committing the key vector.
module input_keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic [15:0] key_o,
  output logic        key_changed_o
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [3:0]    s1_q, s2_q;
  logic [1:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   key_q, key_d;
  logic          kc_q, kc_d;

  logic          sample;
  logic          scan_done;
  logic [15:0]   scan_new;

  // Next-state for the row timer, scan buffer and debounce/commit logic.
  always_comb begin
    sample    = enable_i && (cnt_q == CNT_LAST);
    scan_done = sample && (r_q == 2'd3);
    // The row-3 nibble lands in the buffer on this same edge, so splice it in.
    scan_new  = {s2_q, buf_q[11:0]};
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    row_d     = row_q;
    cand_d    = cand_q;
    stable_d  = stable_q;
    key_d     = key_q;
    kc_d      = 1'b0;
    if (enable_i) begin
      if (sample) begin
        buf_d[{r_q, 2'b00} +: 4] = s2_q;
        cnt_d = '0;
        r_d   = r_q + 2'd1;
        row_d = 4'b0001 << r_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (scan_done) begin
      if (scan_new == cand_q) begin
        if (stable_q < STABLE_MAX) stable_d = stable_q + 1'b1;
      end else begin
        cand_d   = scan_new;
        stable_d = SW'(1);
      end
      // Re-committing the value already on key_o would be a spurious pulse.
      if ((stable_d == STABLE_MAX) && (cand_d != key_q)) begin
        key_d = cand_d;
        kc_d  = 1'b1;
      end
    end
  end

  // State registers; the synchronizer runs regardless of enable_i.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      row_q    <= 4'b0001;
      buf_q    <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      key_q    <= '0;
      kc_q     <= 1'b0;
    end else begin
      s1_q     <= col_i;
      s2_q     <= s1_q;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      buf_q    <= buf_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      key_q    <= key_d;
      kc_q     <= kc_d;
    end
  end

  assign row_o         = row_q;
  assign key_o         = key_q;
  assign key_changed_o = kc_q;

endmodule
